// File: rtl/qflow_pkg.sv
// rtl/qflow_pkg.sv - shared types and constants for the queue flow controller
package qflow_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEQ   = 2'd1,
        RDATA = 2'd2
    } deq_state_t;

endpackage

// File: rtl/qflow_enq_stage.sv
// rtl/qflow_enq_stage.sv - deserializer-to-queue byte register with full check and throttle
module qflow_enq_stage
    import qflow_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              des_valid,
    input  logic [DATA_W-1:0] des_data,
    input  logic [LEN_W-1:0]  q_len,
    output logic              des_write_en,
    output logic              q_enqueue,
    output logic [DATA_W-1:0] q_wdata,
    output logic              overflow,
    output logic [LEN_W:0]    occ
);

    localparam logic [LEN_W:0] FULL_LVL  = (LEN_W+1)'(DEPTH);
    localparam logic [LEN_W:0] SLACK_LVL = (LEN_W+1)'(DEPTH - 1);

    logic full;

    // The byte sitting in q_enqueue is already committed, so it counts as occupied.
    assign occ  = {1'b0, q_len} + {{LEN_W{1'b0}}, q_enqueue};
    assign full = (occ >= FULL_LVL);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_enqueue    <= 1'b0;
            q_wdata      <= '0;
            overflow     <= 1'b0;
            des_write_en <= 1'b0;
        end else begin
            des_write_en <= (occ < SLACK_LVL);
            q_enqueue    <= 1'b0;
            if (des_valid) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    q_enqueue <= 1'b1;
                    q_wdata   <= des_data;
                end
            end
        end
    end

endmodule

// File: rtl/queue_flow_ctrl.sv
// rtl/queue_flow_ctrl.sv - enqueue throttle and one-outstanding dequeue FSM for the byte queue
// Optional watermark auto-drain is enabled by defining QFLOW_AUTODRAIN_EN.
module queue_flow_ctrl
    import qflow_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int LEN_W      = 4,
    parameter int HIGH_WATER = 6,
    parameter int LOW_WATER  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              des_valid,
    input  logic [DATA_W-1:0] des_data,
    output logic              des_write_en,
    input  logic [LEN_W-1:0]  q_len,
    output logic              q_enqueue,
    output logic [DATA_W-1:0] q_wdata,
    output logic              q_dequeue,
    input  logic [DATA_W-1:0] q_rdata,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              overflow,
    output logic              busy
);

    deq_state_t        state;
    logic              pending;
    logic [DATA_W-1:0] rd_hold;
    logic [LEN_W:0]    occ;
    logic              q_nonempty;
    logic              start_deq;

    qflow_enq_stage #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_enq (
        .clock        (clock),
        .reset        (reset),
        .des_valid    (des_valid),
        .des_data     (des_data),
        .q_len        (q_len),
        .des_write_en (des_write_en),
        .q_enqueue    (q_enqueue),
        .q_wdata      (q_wdata),
        .overflow     (overflow),
        .occ          (occ)
    );

    assign q_nonempty = (q_len != '0);

`ifdef QFLOW_AUTODRAIN_EN
    localparam logic [LEN_W:0]   HIGH_LVL = (LEN_W+1)'(HIGH_WATER);
    localparam logic [LEN_W-1:0] LOW_LVL  = LEN_W'(LOW_WATER);

    logic drain;
    logic drain_set;

    assign drain_set = (state == IDLE) && (occ >= HIGH_LVL);
    assign start_deq = q_nonempty && (pending || rd_req || drain || drain_set);

    always_ff @(posedge clock) begin
        if (!reset) begin
            drain <= 1'b0;
        end else if (drain_set) begin
            drain <= 1'b1;
        end else if ((state == RDATA) && (q_len <= LOW_LVL)) begin
            drain <= 1'b0;
        end
    end
`else
    logic unused_water;

    assign start_deq    = q_nonempty && (pending || rd_req);
    assign unused_water = ^{occ, 32'(HIGH_WATER), 32'(LOW_WATER)};
`endif

    // q_rdata is only valid during RDATA, so rd_data passes it through for the
    // rd_valid cycle and then holds the captured copy until the next read.
    assign rd_data = rd_valid ? q_rdata : rd_hold;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            q_dequeue <= 1'b0;
            rd_valid  <= 1'b0;
            rd_hold   <= '0;
            busy      <= 1'b0;
        end else begin
            q_dequeue <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    pending <= pending | rd_req;
                    if (start_deq) begin
                        state     <= DEQ;
                        q_dequeue <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                DEQ: begin
                    pending  <= pending | rd_req;
                    state    <= RDATA;
                    rd_valid <= 1'b1;
                end
                RDATA: begin
                    // An outstanding request is served by this byte; a request
                    // arriving now only counts when none was outstanding.
                    pending <= pending ? 1'b0 : rd_req;
                    rd_hold <= q_rdata;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
